txn_id_tracker: RTL and testbench
=================================

TXN_ID_TRACKER -- requirements
Module: txn_id_tracker

Interface
REQ-001 Params: NUM_IDS, default 8, number of transaction IDs (ID width IDW = 3).
REQ-002 Params: CTX_W, default 16, per-request context width; DATA_W, default 32, response data width; TIMEOUT, default 255, pending-age limit in cycles.
REQ-003 clock  in  1  clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid/req_ready  in/out  1  upstream request handshake; req_ctx  in  CTX_W  request context.
REQ-006 alloc_valid  in  1, alloc_id  in  IDW, alloc_ready  out  1  ID-pool allocation port; a beat is consumed when alloc_valid & alloc_ready.
REQ-007 out_valid/out_ready  out/in  1, out_id  out  IDW, out_ctx  out  CTX_W  tagged request to the fabric.
REQ-008 rsp_valid/rsp_ready  in/out  1, rsp_id  in  IDW, rsp_data  in  DATA_W  fabric response.
REQ-009 done_valid/done_ready  out/in  1, done_ctx  out  CTX_W, done_data  out  DATA_W, done_err  out  1  completed transaction.
REQ-010 free_valid  out  1, free_id  out  IDW  ID return to the pool.
REQ-011 timeout_valid  out  1, timeout_id  out  IDW  one-cycle expiry pulse; spurious  out  1  one-cycle unmatched-response pulse; outstanding  out  IDW+1  pending+expired entry count.

Function
REQ-012 Issue path combinational: out_valid = req_valid & alloc_valid; req_ready = alloc_valid & out_ready; alloc_ready = req_valid & out_ready; out_id = alloc_id; out_ctx = req_ctx.
REQ-013 Issue fires on req_valid & alloc_valid & out_ready; entry[alloc_id] SHALL become PENDING next cycle, storing req_ctx, age = 0.
REQ-014 Per-entry states: FREE, PENDING, EXPIRED; FREE->PENDING on issue; PENDING->EXPIRED when age reaches TIMEOUT; PENDING/EXPIRED->FREE on matching response acceptance.
REQ-015 Age increments by 1 each cycle while PENDING, saturates at TIMEOUT; on PENDING->EXPIRED transition timeout_valid pulses one cycle with timeout_id; if several expire together, lowest ID reported that cycle, others reported in following cycles in ascending order.
REQ-016 Completion output is a one-entry register: rsp_ready = ~done_valid | done_ready.
REQ-017 Accepted response to a PENDING entry: done_valid next cycle with stored ctx, rsp_data, done_err = 0; entry -> FREE.
REQ-018 Accepted response to an EXPIRED entry: same, but done_err = 1.
REQ-019 Accepted response to a FREE entry (including an ID being issued that same cycle): dropped, spurious pulses next cycle, no done, no free.
REQ-020 free_valid/free_id registered, asserted exactly the cycle after a matching response acceptance; at most one free per cycle; no backpressure.
REQ-021 An ID is never reissued before its free has been presented, so issue and matching response to the same ID in one cycle cannot occur legally.
REQ-022 outstanding = number of non-FREE entries, updated same cycle as entry state; simultaneous issue and completion leave it unchanged.
REQ-023 done_valid held with stable payload until done_ready.

Reset
REQ-024 Reset SHALL set all entries FREE, ages 0, done_valid 0, free_valid 0, timeout_valid 0, spurious 0, outstanding 0.
REQ-025 Reset mid-operation discards all pending contexts without generating frees; the ID pool is reset by the same reset.

Structure
REQ-026 Shared package holds entry-state enum (FREE/PENDING/EXPIRED), IDW derivation and default parameter constants.
REQ-027 One sub-module natural: txn_id_entry (state, ctx, age counter per ID), instantiated NUM_IDS times; top holds issue, response, timeout-arbitration and output-register logic.

Verification
REQ-028 Issue ctx 0x1234 with alloc_id 3, respond id 3 data 0xDEADBEEF two cycles later -> done ctx 0x1234 data 0xDEADBEEF err 0, free_id 3 one cycle after response accept, outstanding 1->0.
REQ-029 Issue id 5, no response for 255 cycles -> timeout_valid with id 5 exactly once; later response id 5 -> done_err 1, free_id 5.
REQ-030 Response id 6 with no pending entry -> spurious pulse, no done_valid, no free_valid.
REQ-031 Hold done_ready 0 with a completion pending; second response offered -> rsp_ready 0, first done payload stable; release -> both complete in order.
REQ-032 Issue all 8 IDs, respond 7..0 reversed -> 8 dones with correct ctx, outstanding counts 8 down to 0, frees 7..0.
REQ-033 Assert reset with 4 entries pending -> outstanding 0, no free or done afterwards; late response to an old ID -> spurious.

Source files
------------

// File: rtl/txn_id_tracker_pkg.sv
// ----------------------------------------------------------------------------
// txn_id_tracker_pkg
//   Shared definitions for the transaction ID tracker:
//     - ent_state_e : per-ID entry state (FREE / PENDING / EXPIRED)
//     - DEF_*       : default values for the tracker parameters
//     - id_width()  : ID field width derived from the number of IDs
// ----------------------------------------------------------------------------
package txn_id_tracker_pkg;

   typedef enum logic [1:0] {
      ENT_FREE    = 2'd0,
      ENT_PENDING = 2'd1,
      ENT_EXPIRED = 2'd2
   } ent_state_e;

   localparam int DEF_NUM_IDS = 8;
   localparam int DEF_CTX_W   = 16;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   // A single ID still needs a one-bit field to carry it.
   function automatic int id_width(input int num_ids);
      return (num_ids <= 2) ? 1 : $clog2(num_ids);
   endfunction

endpackage

// File: rtl/txn_id_tracker_if.sv
// ----------------------------------------------------------------------------
// txn_id_tracker_if
//   Bundles every handshake/bus signal of the tracker.
//   Modports:
//     slave  : the tracker itself
//     master : the environment (upstream, ID pool, fabric, completion sink)
//   Groups:
//     req_*     upstream request (valid/ready, ctx)
//     alloc_*   ID-pool allocation beat (valid/ready, id)
//     out_*     tagged request to the fabric (valid/ready, id, ctx)
//     rsp_*     fabric response (valid/ready, id, data)
//     done_*    completed transaction (valid/ready, ctx, data, err)
//     free_*    ID return to the pool (valid, id; no backpressure)
//     timeout_* one-cycle expiry pulse; spurious one-cycle unmatched pulse
//     outstanding  count of non-FREE entries; dbg_state  per-entry state
//
//   Handshake rule for every valid/ready pair: a beat transfers on a rising
//   clock edge where valid and ready are both high; a source holding valid
//   keeps its payload stable until that transfer happens.
// ----------------------------------------------------------------------------
interface txn_id_tracker_if #(
   parameter int NUM_IDS = txn_id_tracker_pkg::DEF_NUM_IDS,
   parameter int CTX_W   = txn_id_tracker_pkg::DEF_CTX_W,
   parameter int DATA_W  = txn_id_tracker_pkg::DEF_DATA_W
);
   localparam int IDW = txn_id_tracker_pkg::id_width(NUM_IDS);

   logic              req_valid;
   logic              req_ready;
   logic [CTX_W-1:0]  req_ctx;

   logic              alloc_valid;
   logic [IDW-1:0]    alloc_id;
   logic              alloc_ready;

   logic              out_valid;
   logic              out_ready;
   logic [IDW-1:0]    out_id;
   logic [CTX_W-1:0]  out_ctx;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [DATA_W-1:0] rsp_data;

   logic              done_valid;
   logic              done_ready;
   logic [CTX_W-1:0]  done_ctx;
   logic [DATA_W-1:0] done_data;
   logic              done_err;

   logic              free_valid;
   logic [IDW-1:0]    free_id;

   logic              timeout_valid;
   logic [IDW-1:0]    timeout_id;
   logic              spurious;
   logic [IDW:0]      outstanding;

   txn_id_tracker_pkg::ent_state_e [NUM_IDS-1:0] dbg_state;

   modport slave (
      input  req_valid, req_ctx,
      input  alloc_valid, alloc_id,
      input  out_ready,
      input  rsp_valid, rsp_id, rsp_data,
      input  done_ready,
      output req_ready, alloc_ready,
      output out_valid, out_id, out_ctx,
      output rsp_ready,
      output done_valid, done_ctx, done_data, done_err,
      output free_valid, free_id,
      output timeout_valid, timeout_id, spurious, outstanding,
      output dbg_state
   );

   modport master (
      output req_valid, req_ctx,
      output alloc_valid, alloc_id,
      output out_ready,
      output rsp_valid, rsp_id, rsp_data,
      output done_ready,
      input  req_ready, alloc_ready,
      input  out_valid, out_id, out_ctx,
      input  rsp_ready,
      input  done_valid, done_ctx, done_data, done_err,
      input  free_valid, free_id,
      input  timeout_valid, timeout_id, spurious, outstanding,
      input  dbg_state
   );

endinterface

// File: rtl/txn_id_entry.sv
// ----------------------------------------------------------------------------
// txn_id_entry
//   Tracking state for a single transaction ID: entry state, stored request
//   context and an age counter that drives the PENDING -> EXPIRED timeout.
//   Ports:
//     clock, reset : clock, synchronous active-high reset
//     issue_i      : this ID is being issued this cycle (load ctx_i)
//     ctx_i        : request context to store on issue
//     clear_i      : a matching response is accepted this cycle (-> FREE)
//     state_o      : registered entry state
//     ctx_o        : stored context
//     expire_o     : this entry moves PENDING -> EXPIRED at the next edge
// ----------------------------------------------------------------------------
module txn_id_entry
   import txn_id_tracker_pkg::*;
#(
   parameter int CTX_W   = DEF_CTX_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             issue_i,
   input  logic [CTX_W-1:0] ctx_i,
   input  logic             clear_i,
   output ent_state_e       state_o,
   output logic [CTX_W-1:0] ctx_o,
   output logic             expire_o
);
   localparam int AGE_W = $clog2(TIMEOUT + 1);
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

   ent_state_e       state_q;
   logic [CTX_W-1:0] ctx_q;
   logic [AGE_W-1:0] age_q;

   // A response arriving on the final pending cycle wins over the timeout.
   assign expire_o = (state_q == ENT_PENDING) && (age_q == AGE_LAST) &&
                     !clear_i && !issue_i;

   // Age only advances while PENDING, so it tops out at TIMEOUT on the
   // same edge the entry becomes EXPIRED and then holds there.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ENT_FREE;
         ctx_q   <= '0;
         age_q   <= '0;
      end else if (issue_i) begin
         state_q <= ENT_PENDING;
         ctx_q   <= ctx_i;
         age_q   <= '0;
      end else if (clear_i) begin
         state_q <= ENT_FREE;
         age_q   <= '0;
      end else if (state_q == ENT_PENDING) begin
         age_q <= age_q + AGE_W'(1);
         if (age_q == AGE_LAST) begin
            state_q <= ENT_EXPIRED;
         end
      end
   end

   assign state_o = state_q;
   assign ctx_o   = ctx_q;

endmodule

// File: rtl/txn_id_tracker.sv
// ----------------------------------------------------------------------------
// txn_id_tracker
//   Tags upstream requests with IDs from an external pool, tracks each
//   outstanding ID until its response returns (or times out), and emits a
//   completion carrying the original context plus the response data.
//   Ports:
//     clock, reset : clock, synchronous active-high reset
//     bus          : txn_id_tracker_if.slave (request, allocation, fabric
//                    request/response, completion, free, timeout, spurious,
//                    outstanding and per-entry debug state)
// ----------------------------------------------------------------------------
module txn_id_tracker
   import txn_id_tracker_pkg::*;
#(
   parameter int NUM_IDS = DEF_NUM_IDS,
   parameter int CTX_W   = DEF_CTX_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic            clock,
   input  logic            reset,
   txn_id_tracker_if.slave bus
);
   localparam int IDW = id_width(NUM_IDS);

   // ---------------- issue path (purely combinational) ----------------
   logic issue_fire;

   assign bus.out_valid   = bus.req_valid & bus.alloc_valid;
   assign bus.req_ready   = bus.alloc_valid & bus.out_ready;
   assign bus.alloc_ready = bus.req_valid & bus.out_ready;
   assign bus.out_id      = bus.alloc_id;
   assign bus.out_ctx     = bus.req_ctx;
   assign issue_fire      = bus.req_valid & bus.alloc_valid & bus.out_ready;

   // ---------------- entries ----------------
   ent_state_e [NUM_IDS-1:0]       ent_state;
   logic [NUM_IDS-1:0][CTX_W-1:0]  ent_ctx;
   logic [NUM_IDS-1:0]             ent_issue;
   logic [NUM_IDS-1:0]             ent_clear;
   logic [NUM_IDS-1:0]             ent_expire;

   logic rsp_ready_w;
   logic rsp_accept;
   logic rsp_match;
   logic rsp_hit;
   logic rsp_expired;
   logic [CTX_W-1:0] rsp_ctx_sel;

   for (genvar g = 0; g < NUM_IDS; g++) begin : g_entry
      assign ent_issue[g] = issue_fire & (bus.alloc_id == IDW'(g));
      assign ent_clear[g] = rsp_hit & (bus.rsp_id == IDW'(g));

      txn_id_entry #(
         .CTX_W   (CTX_W),
         .TIMEOUT (TIMEOUT)
      ) u_entry (
         .clock    (clock),
         .reset    (reset),
         .issue_i  (ent_issue[g]),
         .ctx_i    (bus.req_ctx),
         .clear_i  (ent_clear[g]),
         .state_o  (ent_state[g]),
         .ctx_o    (ent_ctx[g]),
         .expire_o (ent_expire[g])
      );
   end

   assign bus.dbg_state = ent_state;

   // ---------------- response lookup ----------------
   // The completion register is single-entry; it can take a new response
   // whenever it is empty or being drained this cycle.
   logic done_valid_q;

   assign rsp_ready_w   = ~done_valid_q | bus.done_ready;
   assign bus.rsp_ready = rsp_ready_w;
   assign rsp_accept    = bus.rsp_valid & rsp_ready_w;

   // A response only matches an entry that is already non-FREE, so a
   // response to an ID issued in the same cycle is treated as spurious.
   always_comb begin
      rsp_match   = 1'b0;
      rsp_expired = 1'b0;
      rsp_ctx_sel = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (bus.rsp_id == IDW'(i)) begin
            rsp_match   = (ent_state[i] != ENT_FREE);
            rsp_expired = (ent_state[i] == ENT_EXPIRED);
            rsp_ctx_sel = ent_ctx[i];
         end
      end
   end

   assign rsp_hit = rsp_accept & rsp_match;

   // ---------------- timeout arbitration ----------------
   // Expiries that could not be reported yet wait in tmo_pend_q; fresh
   // expiries are merged in so the lowest ID is always reported first.
   logic [NUM_IDS-1:0] tmo_pend_q;
   logic [NUM_IDS-1:0] tmo_pend_d;
   logic [NUM_IDS-1:0] tmo_all;
   logic               tmo_found;
   logic [IDW-1:0]     tmo_sel;

   always_comb begin
      tmo_all    = tmo_pend_q | ent_expire;
      tmo_pend_d = tmo_all;
      tmo_found  = 1'b0;
      tmo_sel    = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         if (tmo_all[i] && !tmo_found) begin
            tmo_found     = 1'b1;
            tmo_sel       = IDW'(i);
            tmo_pend_d[i] = 1'b0;
         end
      end
   end

   // ---------------- outstanding count ----------------
   logic [IDW:0] outstanding_w;

   always_comb begin
      outstanding_w = '0;
      for (int i = 0; i < NUM_IDS; i++) begin
         outstanding_w = outstanding_w + {{IDW{1'b0}}, (ent_state[i] != ENT_FREE)};
      end
   end

   assign bus.outstanding = outstanding_w;

   // ---------------- output registers ----------------
   logic [CTX_W-1:0]  done_ctx_q;
   logic [DATA_W-1:0] done_data_q;
   logic              done_err_q;
   logic              free_valid_q;
   logic [IDW-1:0]    free_id_q;
   logic              spurious_q;
   logic              tmo_valid_q;
   logic [IDW-1:0]    tmo_id_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         done_valid_q <= 1'b0;
         done_ctx_q   <= '0;
         done_data_q  <= '0;
         done_err_q   <= 1'b0;
         free_valid_q <= 1'b0;
         free_id_q    <= '0;
         spurious_q   <= 1'b0;
         tmo_valid_q  <= 1'b0;
         tmo_id_q     <= '0;
         tmo_pend_q   <= '0;
      end else begin
         free_valid_q <= rsp_hit;
         spurious_q   <= rsp_accept & ~rsp_match;
         tmo_valid_q  <= tmo_found;
         tmo_id_q     <= tmo_sel;
         tmo_pend_q   <= tmo_pend_d;

         if (rsp_hit) begin
            free_id_q    <= bus.rsp_id;
            done_valid_q <= 1'b1;
            done_ctx_q   <= rsp_ctx_sel;
            done_data_q  <= bus.rsp_data;
            done_err_q   <= rsp_expired;
         end else if (bus.done_ready) begin
            done_valid_q <= 1'b0;
         end
      end
   end

   assign bus.done_valid    = done_valid_q;
   assign bus.done_ctx      = done_ctx_q;
   assign bus.done_data     = done_data_q;
   assign bus.done_err      = done_err_q;
   assign bus.free_valid    = free_valid_q;
   assign bus.free_id       = free_id_q;
   assign bus.spurious      = spurious_q;
   assign bus.timeout_valid = tmo_valid_q;
   assign bus.timeout_id    = tmo_id_q;

endmodule

// File: tb/tb_txn_id_tracker.sv
// ----------------------------------------------------------------------------
// tb_txn_id_tracker
//   Directed bench for txn_id_tracker. Inputs change on the falling edge;
//   registered outputs are sampled on the falling edge after the rising edge
//   that produced them, combinational outputs #1 after the inputs change.
// ----------------------------------------------------------------------------
module tb_txn_id_tracker;

   logic clock;
   logic reset;

   int errors;
   int checks;

   txn_id_tracker_if #(.NUM_IDS(8), .CTX_W(16), .DATA_W(32)) bus ();

   txn_id_tracker #(
      .NUM_IDS (8),
      .CTX_W   (16),
      .DATA_W  (32),
      .TIMEOUT (255)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / watchdog ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req_valid   = 1'b0;
      bus.req_ctx     = '0;
      bus.alloc_valid = 1'b0;
      bus.alloc_id    = '0;
      bus.out_ready   = 1'b1;
      bus.rsp_valid   = 1'b0;
      bus.rsp_id      = '0;
      bus.rsp_data    = '0;
      bus.done_ready  = 1'b1;
   endtask

   task automatic issue(input logic [2:0] id, input logic [15:0] ctx);
      bus.req_valid   = 1'b1;
      bus.alloc_valid = 1'b1;
      bus.alloc_id    = id;
      bus.req_ctx     = ctx;
      tick();
      bus.req_valid   = 1'b0;
      bus.alloc_valid = 1'b0;
   endtask

   task automatic respond(input logic [2:0] id, input logic [31:0] data);
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = id;
      bus.rsp_data  = data;
      tick();
      bus.rsp_valid = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int tmo_cnt;
   int tmo_cyc;
   int tmo_last;

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      idle_inputs();
      repeat (3) tick();

      // reset state
      chk("rst_outstanding", bus.outstanding, 0);
      chk("rst_done_valid", bus.done_valid, 0);
      chk("rst_free_valid", bus.free_valid, 0);
      chk("rst_timeout_valid", bus.timeout_valid, 0);
      chk("rst_spurious", bus.spurious, 0);
      chk("rst_rsp_ready", bus.rsp_ready, 1);
      reset = 1'b0;
      tick();

      // combinational issue path
      bus.req_valid = 1'b1;
      #1;
      chk("comb_out_valid_noalloc", bus.out_valid, 0);
      chk("comb_req_ready_noalloc", bus.req_ready, 0);
      chk("comb_alloc_ready", bus.alloc_ready, 1);
      bus.alloc_valid = 1'b1;
      bus.alloc_id    = 3'd3;
      bus.req_ctx     = 16'h1234;
      bus.out_ready   = 1'b0;
      #1;
      chk("comb_out_valid_blocked", bus.out_valid, 1);
      chk("comb_req_ready_blocked", bus.req_ready, 0);
      chk("comb_alloc_ready_blocked", bus.alloc_ready, 0);
      tick();
      chk("blocked_no_issue", bus.outstanding, 0);

      // basic issue / response, id 3
      bus.out_ready = 1'b1;
      #1;
      chk("comb_req_ready", bus.req_ready, 1);
      chk("comb_out_id", bus.out_id, 3);
      chk("comb_out_ctx", bus.out_ctx, 16'h1234);
      tick();
      bus.req_valid   = 1'b0;
      bus.alloc_valid = 1'b0;
      chk("basic_outstanding_1", bus.outstanding, 1);
      tick();
      respond(3'd3, 32'hDEADBEEF);
      chk("basic_done_valid", bus.done_valid, 1);
      chk("basic_done_ctx", bus.done_ctx, 16'h1234);
      chk("basic_done_data", bus.done_data, 32'hDEADBEEF);
      chk("basic_done_err", bus.done_err, 0);
      chk("basic_free_valid", bus.free_valid, 1);
      chk("basic_free_id", bus.free_id, 3);
      chk("basic_outstanding_0", bus.outstanding, 0);
      tick();
      chk("basic_done_drained", bus.done_valid, 0);
      chk("basic_free_pulse", bus.free_valid, 0);

      // unmatched response
      respond(3'd6, 32'h00000055);
      chk("spur_pulse", bus.spurious, 1);
      chk("spur_no_done", bus.done_valid, 0);
      chk("spur_no_free", bus.free_valid, 0);
      tick();
      chk("spur_pulse_end", bus.spurious, 0);

      // response to an ID issued in the same cycle is spurious
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = 3'd2;
      bus.rsp_data  = 32'h11111111;
      issue(3'd2, 16'h0202);
      bus.rsp_valid = 1'b0;
      chk("same_cyc_spurious", bus.spurious, 1);
      chk("same_cyc_no_done", bus.done_valid, 0);
      chk("same_cyc_outstanding", bus.outstanding, 1);
      respond(3'd2, 32'hA5A5A5A5);
      chk("same_cyc_late_done", bus.done_valid, 1);
      chk("same_cyc_late_ctx", bus.done_ctx, 16'h0202);
      chk("same_cyc_late_free", bus.free_id, 2);
      chk("same_cyc_late_spur", bus.spurious, 0);
      tick();

      // timeout on id 5
      issue(3'd5, 16'h0505);
      tmo_cnt  = 0;
      tmo_cyc  = 0;
      tmo_last = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (bus.timeout_valid === 1'b1) begin
            tmo_cnt++;
            if (tmo_cnt == 1) begin
               tmo_cyc  = i;
               tmo_last = int'(bus.timeout_id);
            end
         end
      end
      chk("tmo_count", tmo_cnt, 1);
      chk("tmo_cycle", tmo_cyc, 255);
      chk("tmo_id", tmo_last, 5);
      chk("tmo_outstanding", bus.outstanding, 1);
      respond(3'd5, 32'hCAFEF00D);
      chk("tmo_done_valid", bus.done_valid, 1);
      chk("tmo_done_err", bus.done_err, 1);
      chk("tmo_done_ctx", bus.done_ctx, 16'h0505);
      chk("tmo_done_data", bus.done_data, 32'hCAFEF00D);
      chk("tmo_free_id", bus.free_id, 5);
      chk("tmo_outstanding_0", bus.outstanding, 0);
      tick();

      // completion backpressure
      issue(3'd0, 16'h1111);
      issue(3'd1, 16'h2222);
      bus.done_ready = 1'b0;
      respond(3'd0, 32'h00000010);
      chk("bp_first_done", bus.done_valid, 1);
      chk("bp_first_ctx", bus.done_ctx, 16'h1111);
      bus.rsp_valid = 1'b1;
      bus.rsp_id    = 3'd1;
      bus.rsp_data  = 32'h00000020;
      #1;
      chk("bp_rsp_ready_low", bus.rsp_ready, 0);
      tick();
      chk("bp_hold_valid", bus.done_valid, 1);
      chk("bp_hold_ctx", bus.done_ctx, 16'h1111);
      chk("bp_hold_data", bus.done_data, 32'h00000010);
      chk("bp_no_free", bus.free_valid, 0);
      chk("bp_outstanding", bus.outstanding, 1);
      tick();
      chk("bp_hold_data_2", bus.done_data, 32'h00000010);
      chk("bp_rsp_ready_still_low", bus.rsp_ready, 0);
      bus.done_ready = 1'b1;
      #1;
      chk("bp_rsp_ready_release", bus.rsp_ready, 1);
      tick();
      bus.rsp_valid = 1'b0;
      chk("bp_second_done", bus.done_valid, 1);
      chk("bp_second_ctx", bus.done_ctx, 16'h2222);
      chk("bp_second_data", bus.done_data, 32'h00000020);
      chk("bp_second_free", bus.free_id, 1);
      chk("bp_outstanding_0", bus.outstanding, 0);
      tick();
      chk("bp_drained", bus.done_valid, 0);

      // all eight IDs, answered in reverse order
      for (int i = 0; i < 8; i++) begin
         issue(3'(i), 16'hA000 + 16'(i));
         chk("all_outstanding_up", bus.outstanding, i + 1);
      end
      for (int i = 7; i >= 0; i--) begin
         respond(3'(i), 32'h000000B0 + 32'(i));
         chk("all_done_valid", bus.done_valid, 1);
         chk("all_done_ctx", bus.done_ctx, 16'hA000 + 16'(i));
         chk("all_done_data", bus.done_data, 32'h000000B0 + 32'(i));
         chk("all_done_err", bus.done_err, 0);
         chk("all_free_id", bus.free_id, i);
         chk("all_outstanding_down", bus.outstanding, i);
      end
      tick();
      chk("all_drained", bus.done_valid, 0);

      // reset with four entries pending
      for (int i = 0; i < 4; i++) begin
         issue(3'(i), 16'hC000 + 16'(i));
      end
      chk("mid_rst_outstanding_4", bus.outstanding, 4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_outstanding_0", bus.outstanding, 0);
      chk("mid_rst_no_done", bus.done_valid, 0);
      chk("mid_rst_no_free", bus.free_valid, 0);
      tick();
      tick();
      chk("mid_rst_no_free_later", bus.free_valid, 0);
      chk("mid_rst_no_done_later", bus.done_valid, 0);
      respond(3'd2, 32'h0BADF00D);
      chk("mid_rst_late_spurious", bus.spurious, 1);
      chk("mid_rst_late_no_done", bus.done_valid, 0);
      chk("mid_rst_late_no_free", bus.free_valid, 0);

      // discarded entries must never time out
      tmo_cnt = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.timeout_valid !== 1'b0) tmo_cnt++;
      end
      chk("mid_rst_no_timeout", tmo_cnt, 0);
      chk("final_outstanding", bus.outstanding, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
